// File: rtl/pipeline_defs.sv
// Shared definitions for the pipeline stall/bubble sequencer: stall vectors,
// FSM state encoding, register-zero constant and stall-bit index names.
package pipeline_defs;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_EXBUSY  = 2'd1,
        ST_MEMWAIT = 2'd2
    } state_t;

    // Stall vectors; always contiguous from the PC upwards
    localparam logic [4:0] STALL_NONE    = 5'b00000;
    localparam logic [4:0] STALL_LOADUSE = 5'b00011;
    localparam logic [4:0] STALL_EXBUSY  = 5'b00111;
    localparam logic [4:0] STALL_MEMWAIT = 5'b01111;

    // Architectural $0 never carries a dependency
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Stall-bit positions
    localparam int STALL_PC    = 0;
    localparam int STALL_IFID  = 1;
    localparam int STALL_IDEX  = 2;
    localparam int STALL_EXMEM = 3;
    localparam int STALL_MEMWB = 4;

    // Counter width for the EX busy counter; it only ever holds MULT_LAT-2
    function automatic int cnt_width(input int lat);
        return (lat > 2) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/ex_busy_counter.sv
// Loadable down-counter tracking the remaining stall cycles of a multi-cycle
// EX operation. Saturates at zero and flags it.
module ex_busy_counter #(
    parameter int W = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] cnt_q;

    // Load has priority over decrement; decrement stops at zero
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else if (i_load) begin
            cnt_q <= i_load_val;
        end else if (i_dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign o_zero = (cnt_q == '0);

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/bubble sequencer for the 5-stage pipeline. Combines MEM wait
// states, multi-cycle multiplies and load-use hazards into one contiguous
// stall vector, and gates decode's PC redirect against that stall.
// While a multiply is counting, the FSM stays in EXBUSY even under a MEM wait
// (the MEM wait dominates the stall vector); if the count expires during the
// wait, completion is latched and reported once the wait clears.
module pipeline_ctrl
    import pipeline_defs::*;
#(
    parameter int MULT_LAT   = 4,
    parameter bit DELAY_SLOT = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_id_readEnableLeft,
    input  logic       i_id_readEnableRight,
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    input  logic       i_id_takeBranch,
    input  logic       i_ex_isLoad,
    input  logic [4:0] i_ex_dest,
    input  logic       i_ex_isMult,
    input  logic       i_mem_req,
    input  logic       i_mem_ack,
    output logic [4:0] o_stall,
    output logic       o_pcRedirect,
    output logic       o_flushIfId,
    output logic       o_multDone,
    output logic [1:0] o_dbgState
);

    localparam int              CW          = cnt_width(MULT_LAT);
    localparam bit              MULT_STALLS = (MULT_LAT > 1);
    localparam logic [CW-1:0]   CNT_LOAD    = (MULT_LAT > 1) ? CW'(MULT_LAT - 2) : '0;

    state_t     state_q, state_d;
    logic       done_held_q, done_held_d;
    logic       cnt_load, cnt_dec, cnt_zero;
    logic       mem_wait, ex_busy, load_use;
    logic       mult_done_raw;
    logic [4:0] stall_raw;

    ex_busy_counter #(.W(CW)) u_cnt (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (cnt_load),
        .i_load_val (CNT_LOAD),
        .i_dec      (cnt_dec),
        .o_zero     (cnt_zero)
    );

    // Hazard detection and stall priority: MEM wait > EX busy > load-use
    always_comb begin
        mem_wait = (i_mem_req && !i_mem_ack) || ((state_q == ST_MEMWAIT) && !i_mem_ack);
        ex_busy  = ((state_q == ST_EXBUSY) && !cnt_zero) ||
                   ((state_q == ST_RUN) && MULT_STALLS && i_ex_isMult);
        load_use = i_ex_isLoad && (i_ex_dest != REG_ZERO) &&
                   ((i_id_readEnableLeft  && (i_id_rs == i_ex_dest)) ||
                    (i_id_readEnableRight && (i_id_rt == i_ex_dest)));
        if (mem_wait) begin
            stall_raw = STALL_MEMWAIT;
        end else if (ex_busy) begin
            stall_raw = STALL_EXBUSY;
        end else if (load_use) begin
            stall_raw = STALL_LOADUSE;
        end else begin
            stall_raw = STALL_NONE;
        end
    end

    // Next-state, counter control and multiply-complete pulse
    always_comb begin
        state_d       = state_q;
        done_held_d   = done_held_q;
        cnt_load      = 1'b0;
        cnt_dec       = 1'b0;
        mult_done_raw = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mem_wait) begin
                    state_d = ST_MEMWAIT;
                end else if (MULT_STALLS && i_ex_isMult) begin
                    state_d  = ST_EXBUSY;
                    cnt_load = 1'b1;
                end
            end
            ST_EXBUSY: begin
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else if (mem_wait) begin
                    done_held_d = 1'b1;
                    state_d     = ST_MEMWAIT;
                end else begin
                    mult_done_raw = 1'b1;
                    state_d       = ST_RUN;
                end
            end
            ST_MEMWAIT: begin
                if (i_mem_ack) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
        if (done_held_q && !mem_wait) begin
            mult_done_raw = 1'b1;
            done_held_d   = 1'b0;
        end
        if (!MULT_STALLS) begin
            mult_done_raw = i_ex_isMult && !stall_raw[STALL_EXMEM];
        end
    end

    // State and latched-completion registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_RUN;
            done_held_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            done_held_q <= done_held_d;
        end
    end

    // Outputs forced quiet while reset is asserted
    always_comb begin
        o_stall      = i_rst_n ? stall_raw : STALL_NONE;
        o_pcRedirect = i_rst_n && i_id_takeBranch && !stall_raw[STALL_IFID];
        o_flushIfId  = o_pcRedirect && (DELAY_SLOT == 1'b0);
        o_multDone   = i_rst_n && mult_done_raw;
        o_dbgState   = state_q;
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: two instances (MULT_LAT=4/no delay slot and
// MULT_LAT=1/delay slot) share one stimulus and are compared every cycle
// against a cycle-level reference model, plus directed constant checks.
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rdl, rdr, take, is_load, is_mult, mem_req, mem_ack;
    logic [4:0] rs, rt, dest;

    logic [4:0] stall_a, stall_b;
    logic       redir_a, redir_b, flush_a, flush_b, done_a, done_b;
    logic [1:0] dbg_a, dbg_b;

    int n_vec = 0;
    int n_err = 0;

    // Last sampled outputs of the MULT_LAT=4 instance
    logic [4:0] s_stall;
    logic       s_redir, s_flush, s_done, s_flush_b;

    // Reference model: memory-wait flag, multiply in flight with stall
    // cycles still to go, and a completion waiting for a wait to clear
    typedef struct {
        bit in_mem;
        bit mult_busy;
        int mult_rem;
        bit done_pend;
    } mdl_t;

    mdl_t ma, mb;

    always #5 clk = ~clk;

    pipeline_ctrl #(.MULT_LAT(4), .DELAY_SLOT(1'b0)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_id_readEnableLeft(rdl), .i_id_readEnableRight(rdr),
        .i_id_rs(rs), .i_id_rt(rt), .i_id_takeBranch(take),
        .i_ex_isLoad(is_load), .i_ex_dest(dest), .i_ex_isMult(is_mult),
        .i_mem_req(mem_req), .i_mem_ack(mem_ack),
        .o_stall(stall_a), .o_pcRedirect(redir_a), .o_flushIfId(flush_a),
        .o_multDone(done_a), .o_dbgState(dbg_a)
    );

    pipeline_ctrl #(.MULT_LAT(1), .DELAY_SLOT(1'b1)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_id_readEnableLeft(rdl), .i_id_readEnableRight(rdr),
        .i_id_rs(rs), .i_id_rt(rt), .i_id_takeBranch(take),
        .i_ex_isLoad(is_load), .i_ex_dest(dest), .i_ex_isMult(is_mult),
        .i_mem_req(mem_req), .i_mem_ack(mem_ack),
        .o_stall(stall_b), .o_pcRedirect(redir_b), .o_flushIfId(flush_b),
        .o_multDone(done_b), .o_dbgState(dbg_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle of the reference model for the current inputs
    task automatic model_step(input int lat, input bit ds, inout mdl_t m,
                              output logic [4:0] e_stall, output logic e_redir,
                              output logic e_flush, output logic e_done);
        bit   mw, busy, lu;
        int   depth;
        mdl_t nx;
        e_done = 1'b0;
        if (!rst_n) begin
            m       = '{in_mem: 1'b0, mult_busy: 1'b0, mult_rem: 0, done_pend: 1'b0};
            e_stall = 5'd0;
            e_redir = 1'b0;
            e_flush = 1'b0;
        end else begin
            nx    = m;
            mw    = (mem_req && !mem_ack) || (m.in_mem && !mem_ack);
            busy  = m.mult_busy ? (m.mult_rem > 0) : (!m.in_mem && is_mult && lat > 1);
            lu    = is_load && (dest != 5'd0) &&
                    ((rdl && rs == dest) || (rdr && rt == dest));
            depth = mw ? 4 : busy ? 3 : lu ? 2 : 0;
            e_stall = 5'((1 << depth) - 1);
            e_redir = take && (depth < 2);
            e_flush = e_redir && !ds;
            if (lat == 1) e_done = is_mult && !mw;
            if (m.mult_busy) begin
                if (m.mult_rem > 0) begin
                    nx.mult_rem = m.mult_rem - 1;
                end else begin
                    nx.mult_busy = 1'b0;
                    if (mw) begin
                        nx.done_pend = 1'b1;
                        nx.in_mem    = 1'b1;
                    end else begin
                        e_done = 1'b1;
                    end
                end
            end else if (m.in_mem) begin
                if (mem_ack) nx.in_mem = 1'b0;
            end else if (mw) begin
                nx.in_mem = 1'b1;
            end else if (is_mult && lat > 1) begin
                nx.mult_busy = 1'b1;
                nx.mult_rem  = lat - 2;
            end
            if (m.done_pend && !mw) begin
                e_done       = 1'b1;
                nx.done_pend = 1'b0;
            end
            m = nx;
        end
    endtask

    // Sample on the falling edge, compare both instances, advance to after the rising edge
    task automatic step();
        logic [4:0] es;
        logic       er, ef, ed;
        @(negedge clk);
        s_stall   = stall_a;
        s_redir   = redir_a;
        s_flush   = flush_a;
        s_done    = done_a;
        s_flush_b = flush_b;
        model_step(4, 1'b0, ma, es, er, ef, ed);
        check("a_stall", 32'(stall_a), 32'(es));
        check("a_redirect", 32'(redir_a), 32'(er));
        check("a_flush", 32'(flush_a), 32'(ef));
        check("a_multdone", 32'(done_a), 32'(ed));
        model_step(1, 1'b1, mb, es, er, ef, ed);
        check("b_stall", 32'(stall_b), 32'(es));
        check("b_redirect", 32'(redir_b), 32'(er));
        check("b_flush", 32'(flush_b), 32'(ef));
        check("b_multdone", 32'(done_b), 32'(ed));
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rdl = 1'b0; rdr = 1'b0; rs = 5'd0; rt = 5'd0; take = 1'b0;
        is_load = 1'b0; dest = 5'd0; is_mult = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
    endtask

    initial begin
        ma = '{in_mem: 1'b0, mult_busy: 1'b0, mult_rem: 0, done_pend: 1'b0};
        mb = ma;

        // Reset with hazard-provoking inputs: everything must stay quiet
        rst_n = 1'b0;
        idle();
        is_mult = 1'b1; mem_req = 1'b1; take = 1'b1;
        is_load = 1'b1; dest = 5'd5; rdl = 1'b1; rs = 5'd5;
        step();
        check("reset_stall", 32'(s_stall), 32'h0);
        check("reset_redirect", 32'(s_redir), 32'h0);
        check("reset_multdone", 32'(s_done), 32'h0);
        idle();
        step();
        rst_n = 1'b1;
        step();

        // Load-use on rs, then the load leaves EX, then $0 destination
        is_load = 1'b1; dest = 5'd5; rdl = 1'b1; rs = 5'd5;
        step();
        check("loaduse_stall", 32'(s_stall), 32'h03);
        is_load = 1'b0;
        step();
        check("loaduse_release", 32'(s_stall), 32'h00);
        is_load = 1'b1; dest = 5'd0; rs = 5'd0;
        step();
        check("loaduse_zero", 32'(s_stall), 32'h00);
        is_load = 1'b1; dest = 5'd9; rdl = 1'b0; rdr = 1'b1; rt = 5'd9;
        step();
        check("loaduse_rt", 32'(s_stall), 32'h03);
        idle();
        step();

        // Multiply: three held cycles, completion on the fourth EX cycle
        is_mult = 1'b1;
        step();
        check("mult_stall0", 32'(s_stall), 32'h07);
        is_mult = 1'b0;
        step();
        check("mult_stall1", 32'(s_stall), 32'h07);
        step();
        check("mult_stall2", 32'(s_stall), 32'h07);
        check("mult_notdone", 32'(s_done), 32'h0);
        step();
        check("mult_done", 32'(s_done), 32'h1);
        check("mult_release", 32'(s_stall), 32'h00);
        step();
        check("mult_after", 32'(s_done), 32'h0);

        // Memory wait: three waiting cycles, released on the ack cycle
        mem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("memwait_stall", 32'(s_stall), 32'h0f);
        end
        mem_ack = 1'b1;
        step();
        check("memwait_ack", 32'(s_stall), 32'h00);
        idle();
        step();

        // Multiply overlapped by a memory wait: one completion, on the ack cycle
        is_mult = 1'b1;
        step();
        is_mult = 1'b0; mem_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("overlap_stall", 32'(s_stall), 32'h0f);
            check("overlap_nodone", 32'(s_done), 32'h0);
        end
        mem_ack = 1'b1;
        step();
        check("overlap_done", 32'(s_done), 32'h1);
        check("overlap_release", 32'(s_stall), 32'h00);
        idle();
        step();
        check("overlap_once", 32'(s_done), 32'h0);

        // Branch during load-use is refused, accepted on the next cycle
        take = 1'b1; is_load = 1'b1; dest = 5'd7; rdl = 1'b1; rs = 5'd7;
        step();
        check("branch_stalled", 32'(s_redir), 32'h0);
        is_load = 1'b0;
        step();
        check("branch_taken", 32'(s_redir), 32'h1);
        check("branch_flush", 32'(s_flush), 32'h1);
        check("branch_dslot_noflush", 32'(s_flush_b), 32'h0);
        idle();
        step();

        // Reset in the middle of a multiply
        is_mult = 1'b1;
        step();
        is_mult = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset_stall", 32'(stall_a), 32'h0);
        check("midreset_done", 32'(done_a), 32'h0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("postreset_stall", 32'(s_stall), 32'h0);
            check("postreset_done", 32'(s_done), 32'h0);
        end

        // Randomized traffic; memory requests stay up until acknowledged
        for (int i = 0; i < 400; i++) begin
            rst_n   = ($urandom_range(0, 149) != 0);
            rdl     = 1'($urandom_range(0, 1));
            rdr     = 1'($urandom_range(0, 1));
            rs      = 5'($urandom_range(0, 3));
            rt      = 5'($urandom_range(0, 3));
            dest    = 5'($urandom_range(0, 3));
            take    = ($urandom_range(0, 3) == 0);
            is_load = ($urandom_range(0, 2) == 0);
            is_mult = ($urandom_range(0, 5) == 0);
            if (!(mem_req && !mem_ack)) mem_req = ($urandom_range(0, 4) == 0);
            mem_ack = mem_req ? ($urandom_range(0, 2) == 0) : 1'b0;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
